// File: rtl/sm_trace_buf_pkg.sv
// sm_trace_buf_pkg: shared definitions for the sm_cpu instruction-trace unit.
//   - state encodings reported on the `state` output
//   - entry layout helpers: each entry is {stamp, pc, instr}, with instr in the LSBs
package sm_trace_buf_pkg;

  localparam logic [1:0] TS_IDLE  = 2'd0;
  localparam logic [1:0] TS_ARMED = 2'd1;
  localparam logic [1:0] TS_POST  = 2'd2;
  localparam logic [1:0] TS_DONE  = 2'd3;

  localparam int INSTR_LSB = 0;

  function automatic int pcLsb(input int pcW);
    return INSTR_LSB + pcW;
  endfunction

  function automatic int stampLsb(input int pcW);
    return INSTR_LSB + 2 * pcW;
  endfunction

  function automatic int entryW(input int stampW, input int pcW);
    return stampW + 2 * pcW;
  endfunction

endpackage

// File: rtl/sm_trace_buf_if.sv
// sm_trace_buf_if: read-back port of the trace buffer.
//   rd_en    master->slave  read request (honoured only once capture is done)
//   rd_idx   master->slave  entry index, 0 = oldest
//   rd_data  slave->master  {stamp, pc, instr}, valid one cycle after rd_en
//   rd_valid slave->master  rd_data valid
interface sm_trace_buf_if
  import sm_trace_buf_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = entryW(16, 32)
);
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  modport master (output rd_en, rd_idx, input rd_data, rd_valid);
  modport slave  (input rd_en, rd_idx, output rd_data, rd_valid);
endinterface

// File: rtl/sm_trace_buf_ram.sv
// sm_trace_buf_ram: simple dual-port trace storage, synchronous write, registered read.
//   clk     clock
//   wrEn    write strobe, wrAddr/wrData
//   rdEn    read strobe, rdAddr; rdData updates on the following edge
// Contents are not reset.
module sm_trace_buf_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 80
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [W-1:0]  wrData,
  input  logic          rdEn,
  input  logic [AW-1:0] rdAddr,
  output logic [W-1:0]  rdData
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/sm_trace_buf.sv
// sm_trace_buf: instruction-trace capture for sm_cpu. Records {cycle stamp, pc, instr}
// into a circular buffer on every cap_valid cycle while capturing, with free-run
// (stop-terminated) or pc-match trigger modes plus a cycle timeout. Read back via
// the rd interface once capture is DONE.
//   clk, rst            clock, synchronous active-high reset
//   cap_valid/pc/instr  CPU tap
//   arm, stop           start (clears) / end free-run capture
//   trig_en, trig_pc    trigger mode select and match value
//   rd                  read-back port (slave)
//   state               IDLE=0 ARMED=1 POST=2 DONE=3
//   count               valid entries, saturates at DEPTH
//   trig_hit, timeout   sticky status
//   cycle_cnt           cycles since arm
//
// state | meaning
// IDLE  | no capture, waiting for arm
// ARMED | capturing, waiting for trigger / stop / timeout
// POST  | trigger seen, capturing POST_TRIG further entries
// DONE  | capture frozen, buffer readable
module sm_trace_buf
  import sm_trace_buf_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int AW        = 6,
  parameter int PC_W      = 32,
  parameter int STAMP_W   = 16,
  parameter int POST_TRIG = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cap_valid,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] instr,
  input  logic            arm,
  input  logic            stop,
  input  logic            trig_en,
  input  logic [PC_W-1:0] trig_pc,
  sm_trace_buf_if.slave   rd,
  output logic [1:0]      state,
  output logic [AW:0]     count,
  output logic            trig_hit,
  output logic            timeout,
  output logic [31:0]     cycle_cnt
);
  localparam int          EW        = entryW(STAMP_W, PC_W);
  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_LOAD = (AW+1)'(POST_TRIG);
  localparam logic [31:0] CYC_LAST  = 32'(TIMEOUT - 1);

  logic [AW-1:0] wrPtr;
  logic [AW:0]   postCnt;
  logic          capturing, wrEn, pcMatch, cycLast, readOk;
  logic          rdValidQ, rdZeroQ;
  logic [AW-1:0] rdAddr;
  logic [EW-1:0] wrData, ramQ;

  assign capturing = (state == TS_ARMED) || (state == TS_POST);
  // arm restarts the buffer, so the arm cycle itself is never recorded.
  assign wrEn      = capturing && cap_valid && !arm && !rst;
  assign pcMatch   = (state == TS_ARMED) && trig_en && cap_valid && (pc == trig_pc);
  assign cycLast   = capturing && (cycle_cnt == CYC_LAST);
  assign wrData    = {cycle_cnt[STAMP_W-1:0], pc, instr};
  assign readOk    = (state == TS_DONE) && rd.rd_en;
  // Once the buffer has wrapped the oldest entry sits at wrPtr; AW-bit add wraps mod DEPTH.
  assign rdAddr    = ((count == FULL) ? wrPtr : '0) + rd.rd_idx;

  sm_trace_buf_ram #(.DEPTH(DEPTH), .AW(AW), .W(EW)) u_ram (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrPtr),
    .wrData (wrData),
    .rdEn   (readOk),
    .rdAddr (rdAddr),
    .rdData (ramQ)
  );

  assign rd.rd_valid = rdValidQ;
  assign rd.rd_data  = (rdValidQ && !rdZeroQ) ? ramQ : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TS_IDLE;
      wrPtr     <= '0;
      count     <= '0;
      postCnt   <= '0;
      cycle_cnt <= '0;
      trig_hit  <= 1'b0;
      timeout   <= 1'b0;
      rdValidQ  <= 1'b0;
      rdZeroQ   <= 1'b0;
    end else begin
      rdValidQ <= readOk;
      if (readOk) rdZeroQ <= ({1'b0, rd.rd_idx} >= count);

      if (arm) begin
        state     <= TS_ARMED;
        wrPtr     <= '0;
        count     <= '0;
        postCnt   <= '0;
        cycle_cnt <= '0;
        trig_hit  <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        if (wrEn) begin
          wrPtr <= wrPtr + 1'b1;
          if (count != FULL) count <= count + 1'b1;
        end
        if (pcMatch) trig_hit <= 1'b1;

        // Timeout wins over trigger/stop and freezes cycle_cnt at TIMEOUT-1.
        if (cycLast) begin
          timeout <= 1'b1;
          state   <= TS_DONE;
        end else if (capturing) begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (state == TS_ARMED) begin
            if (pcMatch) begin
              postCnt <= POST_LOAD;
              state   <= (POST_TRIG == 0) ? TS_DONE : TS_POST;
            end else if (stop && !trig_en) begin
              state <= TS_DONE;
            end
          end else if (cap_valid) begin
            postCnt <= postCnt - 1'b1;
            if (postCnt == (AW+1)'(1)) state <= TS_DONE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sm_trace_buf.sv
module tb_sm_trace_buf;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int PC_W  = 32;
  localparam int SW    = 16;
  localparam int PT    = 4;
  localparam int TO    = 256;
  localparam int DW    = SW + 2 * PC_W;

  logic            clk = 1'b0;
  logic            rst, cap_valid, arm, stop, trig_en;
  logic [PC_W-1:0] pc, instr, trig_pc;
  logic [1:0]      state;
  logic [AW:0]     count;
  logic            trig_hit, timeout;
  logic [31:0]     cycle_cnt;

  sm_trace_buf_if #(.AW(AW), .DW(DW)) rdBus ();

  sm_trace_buf #(
    .DEPTH(DEPTH), .AW(AW), .PC_W(PC_W), .STAMP_W(SW), .POST_TRIG(PT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .pc(pc), .instr(instr),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd(rdBus), .state(state), .count(count), .trig_hit(trig_hit),
    .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];

  // Reference model: the captured trace is simply the list of recorded entries,
  // trimmed to the newest DEPTH.
  logic [DW-1:0] mq[$];
  int            mState = 0;
  logic [31:0]   mCycle = 0;
  bit            mTrig = 0, mTimeout = 0;
  int            mPost = 0;

  task automatic modelStep(input bit cv, input logic [31:0] p, input logic [31:0] ins,
                           input bit a, input bit s);
    bit match;
    if (a) begin
      mq.delete(); mCycle = 0; mTrig = 0; mTimeout = 0; mState = 1;
      return;
    end
    if (mState == 1 || mState == 2) begin
      match = (mState == 1) && trig_en && cv && (p == trig_pc);
      if (cv) begin
        mq.push_back({mCycle[SW-1:0], p, ins});
        if (mq.size() > DEPTH) mq.delete(0);
      end
      if (match) mTrig = 1;
      if (mCycle == 32'(TO - 1)) begin
        mTimeout = 1; mState = 3;
      end else begin
        mCycle = mCycle + 1;
        if (mState == 1) begin
          if (match) begin
            mPost = PT; mState = (PT == 0) ? 3 : 2;
          end else if (s && !trig_en) mState = 3;
        end else if (cv) begin
          mPost = mPost - 1;
          if (mPost == 0) mState = 3;
        end
      end
    end
  endtask

  task automatic tick(input bit cv, input logic [31:0] p, input logic [31:0] ins,
                      input bit a, input bit s);
    cap_valid = cv; pc = p; instr = ins; arm = a; stop = s;
    modelStep(cv, p, ins, a, s);
    @(posedge clk); #1;
    arm = 0; stop = 0;
  endtask

  task automatic doReset();
    rst = 1; cap_valid = 0; arm = 0; stop = 0;
    @(posedge clk); #1;
    rst = 0;
    mq.delete(); mState = 0; mCycle = 0; mTrig = 0; mTimeout = 0; mPost = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic checkStatus(input string tag);
    chk({tag, "_state"},    32'(state),     32'(mState));
    chk({tag, "_count"},    32'(count),     32'(mq.size()));
    chk({tag, "_trig_hit"}, 32'(trig_hit),  32'(mTrig));
    chk({tag, "_timeout"},  32'(timeout),   32'(mTimeout));
    chk({tag, "_cycle"},    cycle_cnt,      mCycle);
  endtask

  task automatic readIdx(input int idx);
    logic [DW-1:0] e;
    rdBus.rd_en  = 1'b1;
    rdBus.rd_idx = idx[AW-1:0];
    if (mState == 3) begin
      e = (idx < mq.size()) ? mq[idx] : '0;
      sbq.push_back('{e, cyc + 1});
    end
    tick(0, 0, 0, 0, 0);
    rdBus.rd_en = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1; cap_valid = 0; arm = 0; stop = 0; trig_en = 0;
    pc = 0; instr = 0; trig_pc = 0;
    rdBus.rd_en = 0; rdBus.rd_idx = '0;

    fork
      forever begin
        @(negedge clk);
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          e = sbq.pop_front();
          total++;
          if (rdBus.rd_valid !== 1'b1 || rdBus.rd_data !== e.data) begin
            bad++;
            $display("FAIL rd_data@%0d: valid=%b data=0x%0h expected valid=1 data=0x%0h",
                     cyc, rdBus.rd_valid, rdBus.rd_data, e.data);
          end
        end else if (rdBus.rd_valid !== 1'b0) begin
          total++; bad++;
          $display("FAIL rd_valid@%0d: got %b expected 0", cyc, rdBus.rd_valid);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    doReset();
    checkStatus("reset");
    chk("reset_rd_data", 32'(rdBus.rd_data[31:0]), 32'd0);

    // 1: free-run, 10 entries
    trig_en = 0;
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick(1, 32'(i), $urandom, 0, 0);
    tick(0, 0, 0, 0, 1);
    checkStatus("fr");
    chk("fr_done", 32'(state), 32'd3);
    chk("fr_count10", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) readIdx(i);
    readIdx(10);
    readIdx(63);

    // 2: wrap, 70 entries
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 70; i++) tick(1, 32'(i), $urandom, 0, 0);
    tick(0, 0, 0, 0, 1);
    checkStatus("wrap");
    chk("wrap_count64", 32'(count), 32'd64);
    readIdx(0);
    readIdx(63);
    for (int i = 0; i < 4; i++) readIdx($urandom_range(0, DEPTH - 1));

    // 3: trigger at pc=20, 4 post entries
    trig_en = 1; trig_pc = 20;
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i <= 40; i++) tick(1, 32'(i), $urandom, 0, 1);
    checkStatus("trig");
    chk("trig_count25", 32'(count), 32'd25);
    chk("trig_hit1", 32'(trig_hit), 32'd1);
    readIdx(24);
    readIdx(20);
    readIdx(0);
    readIdx(25);

    // 4: timeout, no match
    trig_pc = 32'hFFFF_FFFF;
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) tick(1, 32'(i), $urandom, 0, 0);
    checkStatus("tmo");
    chk("tmo_cycle255", cycle_cnt, 32'd255);
    chk("tmo_flag", 32'(timeout), 32'd1);
    readIdx(0);
    readIdx(63);

    // 5a: cap_valid gaps
    trig_en = 0;
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick(i[0] == 1'b0, 32'(100 + i), $urandom, 0, 0);
    tick(0, 0, 0, 0, 1);
    checkStatus("gap");
    for (int i = 0; i < 10; i++) readIdx(i);

    // 5b: arm and stop together in DONE
    tick(0, 0, 0, 1, 1);
    checkStatus("armstop");
    chk("armstop_state", 32'(state), 32'd1);

    // 5c: reset while in POST
    trig_en = 1; trig_pc = 5;
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i <= 6; i++) tick(1, 32'(i), $urandom, 0, 0);
    chk("post_state", 32'(state), 32'd2);
    doReset();
    checkStatus("rstpost");
    readIdx(0);
    chk("rstpost_rd_valid", 32'(rdBus.rd_valid), 32'd0);

    // randomized captures
    for (int r = 0; r < 4; r++) begin
      trig_en = 1'($urandom_range(0, 1));
      trig_pc = 32'($urandom_range(0, 15));
      tick(0, 0, 0, 1, 0);
      for (int k = 0; k < 300 && mState != 3; k++)
        tick(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom, 0,
             ($urandom_range(0, 19) == 0));
      checkStatus("rnd");
      for (int k = 0; k < 8; k++) readIdx($urandom_range(0, DEPTH - 1));
    end

    repeat (3) tick(0, 0, 0, 0, 0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
